// File: rtl/uart_prog_sender.sv
// Streams a byte image from a synchronous memory into the op_uart CSR port:
// programs divisor and thru once, then writes each byte and waits for tx_irq.
`timescale 1ns/1ps
module uart_prog_sender #(
    parameter int          AW         = 12,
    parameter logic [15:0] DIVISOR    = 16'd27,
    parameter int          TX_TIMEOUT = 20000
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   img_len,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_data,
    output logic [13:0]   csr_a,
    output logic          csr_we,
    output logic [31:0]   csr_di,
    input  logic          tx_irq,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   sent_cnt
);
    localparam int            TW       = $clog2(TX_TIMEOUT + 1);
    // Leaving WAIT_TX when the count would reach TX_TIMEOUT-1 puts ERR
    // exactly TX_TIMEOUT cycles after the data write.
    localparam logic [TW-1:0] TMO_LAST = TW'(TX_TIMEOUT - 2);

    typedef enum logic [3:0] {
        IDLE, CFG_DIV, CFG_THRU, FETCH, LOAD, WRITE, WAIT_TX, DONE, ERR
    } state_t;

    state_t          state, state_d;
    logic            mem_rd_d, csr_we_d, busy_d, done_d, err_d;
    logic [AW-1:0]   mem_addr_d;
    logic [13:0]     csr_a_d;
    logic [31:0]     csr_di_d;
    logic [AW:0]     sent_cnt_d;
    logic [AW:0]     img_len_q;
    logic [TW-1:0]   tmo_cnt, tmo_cnt_d;
    logic            tx_irq_q;
    logic            tx_edge, last_byte, can_start;

    // mem_addr doubles as the byte index of the current run.
    assign tx_edge   = tx_irq & ~tx_irq_q;
    assign last_byte = ({1'b0, mem_addr} == img_len_q - 1'b1);
    assign can_start = start && (state == IDLE || state == DONE || state == ERR);

    always_comb begin
        state_d    = state;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr;
        csr_we_d   = 1'b0;
        csr_a_d    = csr_a;
        csr_di_d   = csr_di;
        busy_d     = busy;
        done_d     = 1'b0;
        err_d      = err;
        sent_cnt_d = sent_cnt;
        tmo_cnt_d  = tmo_cnt;

        case (state)
            IDLE, DONE, ERR: begin
                if (can_start) begin
                    err_d      = 1'b0;
                    sent_cnt_d = '0;
                    mem_addr_d = '0;
                    if (img_len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d  = CFG_DIV;
                        busy_d   = 1'b1;
                        csr_we_d = 1'b1;
                        csr_a_d  = 14'd1;
                        csr_di_d = {16'h0, DIVISOR};
                    end
                end else if (state == DONE) begin
                    state_d = IDLE;
                end
            end
            CFG_DIV: begin
                state_d  = CFG_THRU;
                csr_we_d = 1'b1;
                csr_a_d  = 14'd2;
                csr_di_d = 32'h0;
            end
            CFG_THRU: begin
                state_d  = FETCH;
                mem_rd_d = 1'b1;
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                state_d  = WRITE;
                csr_we_d = 1'b1;
                csr_a_d  = 14'd0;
                csr_di_d = {24'h0, mem_data};
            end
            WRITE: begin
                state_d   = WAIT_TX;
                tmo_cnt_d = '0;
            end
            WAIT_TX: begin
                tmo_cnt_d = tmo_cnt + 1'b1;
                if (tx_edge) begin
                    sent_cnt_d = sent_cnt + 1'b1;
                    if (last_byte) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = FETCH;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = mem_addr + 1'b1;
                    end
                end else if (tmo_cnt == TMO_LAST) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything except a byte confirmation seen this cycle.
        if (abort && state != IDLE) begin
            state_d    = ERR;
            mem_rd_d   = 1'b0;
            mem_addr_d = mem_addr;
            csr_we_d   = 1'b0;
            csr_a_d    = csr_a;
            csr_di_d   = csr_di;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            err_d      = 1'b1;
            if (state != WAIT_TX)
                sent_cnt_d = sent_cnt;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            csr_we   <= 1'b0;
            csr_a    <= '0;
            csr_di   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            sent_cnt <= '0;
            tmo_cnt  <= '0;
            tx_irq_q <= 1'b0;
        end else begin
            state    <= state_d;
            mem_rd   <= mem_rd_d;
            mem_addr <= mem_addr_d;
            csr_we   <= csr_we_d;
            csr_a    <= csr_a_d;
            csr_di   <= csr_di_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            sent_cnt <= sent_cnt_d;
            tmo_cnt  <= tmo_cnt_d;
            tx_irq_q <= tx_irq;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (can_start)
            img_len_q <= img_len;
    end

endmodule

// File: tb/tb_uart_prog_sender.sv
// Bench for uart_prog_sender: byte memory model, tx_irq responder, CSR/memory
// traffic logger, a vector table of whole runs plus hand-written corner cases.
`timescale 1ns/1ps
module tb_uart_prog_sender;
    localparam int          AW  = 12;
    localparam int          TMO = 300;
    localparam logic [15:0] DIV = 16'd27;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   img_len = '0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [13:0]   csr_a;
    logic          csr_we;
    logic [31:0]   csr_di;
    logic          tx_irq;
    logic          busy, done, err;
    logic [AW:0]   sent_cnt;

    always #5 clk = ~clk;

    uart_prog_sender #(.AW(AW), .DIVISOR(DIV), .TX_TIMEOUT(TMO)) dut (
        .sys_clk(clk), .sys_rst(rst), .start(start), .abort(abort), .img_len(img_len),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .tx_irq(tx_irq),
        .busy(busy), .done(done), .err(err), .sent_cnt(sent_cnt)
    );

    // synchronous byte memory
    logic [7:0] mem [2**AW];
    always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

    // tx_irq responder: one-cycle pulse tx_dly cycles after each data write
    int   tx_dly = 50;
    bit   tx_en = 1'b1;
    int   tx_cnt;
    logic tx_auto, tx_man = 1'b0;
    assign tx_irq = tx_auto | tx_man;
    always @(posedge clk) begin
        if (rst) begin
            tx_cnt  <= 0;
            tx_auto <= 1'b0;
        end else begin
            tx_auto <= 1'b0;
            if (tx_cnt > 0) begin
                tx_cnt <= tx_cnt - 1;
                if (tx_cnt == 1) tx_auto <= 1'b1;
            end
            if (tx_en && csr_we && csr_a == 14'd0) tx_cnt <= tx_dly;
        end
    end

    // traffic logger
    typedef struct { logic [13:0] a; logic [31:0] d; int cyc; } wr_t;
    wr_t  wq[$];
    int   rq[$];
    int   done_cnt = 0;
    int   cyc = 0;
    int   err_rise = -1;
    logic err_prev = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            err_prev = 1'b0;
        end else begin
            if (csr_we) wq.push_back('{csr_a, csr_di, cyc});
            if (mem_rd) rq.push_back(int'(mem_addr));
            if (done) done_cnt++;
            if (err && !err_prev) err_rise = cyc;
            err_prev = err;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_pulse(input int len);
        img_len = (AW+1)'(len);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string nm, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done || err) seen = 1'b1;
        end
        chk({nm, "_end_reached"}, longint'(seen), 1);
        repeat (3) tick();
    endtask

    // expected traffic: divisor, thru, then one data write per byte in order
    task automatic chk_seq(input string nm, input int bw, input int br, input int nw, input int nr);
        bit ok = 1'b1;
        if (wq.size() < bw + nw || rq.size() < br + nr) begin
            ok = 1'b0;
        end else begin
            for (int k = 0; k < nw; k++) begin
                logic [13:0] ea;
                logic [31:0] ed;
                if (k == 0) begin ea = 14'd1; ed = {16'h0, DIV}; end
                else if (k == 1) begin ea = 14'd2; ed = 32'h0; end
                else begin ea = 14'd0; ed = {24'h0, mem[k-2]}; end
                if (wq[bw+k].a !== ea || wq[bw+k].d !== ed) ok = 1'b0;
            end
            for (int k = 0; k < nr; k++)
                if (rq[br+k] != k) ok = 1'b0;
        end
        chk({nm, "_seq"}, longint'(ok), 1);
    endtask

    typedef struct {
        int len; int dly; bit en;
        int sent; bit err; int ndone; int nwr; int nrd;
    } vec_t;
    vec_t vt[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bw, br, bd;
        for (int i = 0; i < 2**AW; i++) mem[i] = 8'((i * 37 + 11) ^ (i >> 8));
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h23;

        vt[0] = '{3, 50, 1'b1, 3, 1'b0, 1, 5, 3};
        vt[1] = '{1,  4, 1'b1, 1, 1'b0, 1, 3, 1};
        vt[2] = '{5,  1, 1'b1, 5, 1'b0, 1, 7, 5};
        vt[3] = '{0,  4, 1'b1, 0, 1'b0, 1, 0, 0};
        vt[4] = '{2,  0, 1'b0, 0, 1'b1, 0, 3, 1};

        // reset state
        repeat (2) tick();
        chk("rst_ctrl", longint'({csr_we, mem_rd, busy, done, err}), 0);
        chk("rst_data", longint'({csr_a, csr_di, mem_addr, sent_cnt}), 0);
        @(posedge clk); #1; rst = 1'b0;
        repeat (2) tick();

        foreach (vt[v]) begin
            bw = wq.size(); br = rq.size(); bd = done_cnt;
            tx_dly = vt[v].dly; tx_en = vt[v].en;
            start_pulse(vt[v].len);
            wait_end($sformatf("v%0d", v), vt[v].len * (vt[v].dly + 10) + TMO + 50);
            chk($sformatf("v%0d_sent", v), longint'(sent_cnt), vt[v].sent);
            chk($sformatf("v%0d_err", v), longint'(err), longint'(vt[v].err));
            chk($sformatf("v%0d_busy", v), longint'(busy), 0);
            chk($sformatf("v%0d_done_pulses", v), done_cnt - bd, vt[v].ndone);
            chk($sformatf("v%0d_writes", v), wq.size() - bw, vt[v].nwr);
            chk($sformatf("v%0d_reads", v), rq.size() - br, vt[v].nrd);
            chk_seq($sformatf("v%0d", v), bw, br, vt[v].nwr, vt[v].nrd);
            if (vt[v].err && wq.size() > bw + 2)
                chk($sformatf("v%0d_tmo_latency", v), err_rise - wq[bw+2].cyc, TMO);
        end
        tx_en = 1'b1;

        // empty image: done at T+1, no traffic
        bw = wq.size();
        start_pulse(0);
        tick();
        chk("len0_done_t1", longint'({done, busy, csr_we}), 3'b100);
        repeat (3) tick();
        chk("len0_no_we", wq.size() - bw, 0);

        // abort during the second WAIT_TX, then a clean rerun
        bw = wq.size(); br = rq.size();
        tx_dly = 50;
        start_pulse(4);
        for (int i = 0; i < 500 && wq.size() < bw + 4; i++) tick();
        chk("abort_reached_2nd_write", wq.size() - bw, 4);
        repeat (10) tick();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        tick();
        chk("abort_err_state", longint'({err, busy}), 2'b10);
        chk("abort_sent", longint'(sent_cnt), 1);
        repeat (60) tick();
        chk("abort_no_more_we", wq.size() - bw, 4);
        chk("abort_no_more_rd", rq.size() - br, 2);
        chk("abort_sent_hold", longint'(sent_cnt), 1);

        bw = wq.size(); br = rq.size();
        tx_dly = 5;
        start_pulse(4);
        tick();
        chk("rerun_t1", longint'({err, busy, csr_we, csr_a, csr_di}),
            longint'({1'b0, 1'b1, 1'b1, 14'd1, 16'h0, DIV}));
        wait_end("rerun", 400);
        chk("rerun_sent", longint'(sent_cnt), 4);
        chk("rerun_err", longint'(err), 0);
        chk_seq("rerun", bw, br, 6, 4);

        // full 2**AW image
        bw = wq.size(); br = rq.size(); bd = done_cnt;
        tx_dly = 1;
        start_pulse(2**AW);
        wait_end("full", 2**AW * 8 + 100);
        chk("full_sent", longint'(sent_cnt), 2**AW);
        chk("full_reads", rq.size() - br, 2**AW);
        chk("full_last_addr", (rq.size() > 0) ? rq[rq.size()-1] : -1, 2**AW - 1);
        chk("full_done_pulses", done_cnt - bd, 1);
        chk_seq("full", bw, br, 2**AW + 2, 2**AW);

        // spurious tx_irq edge while idle
        bw = wq.size();
        tx_man = 1'b1;
        repeat (2) tick();
        tx_man = 1'b0;
        repeat (2) tick();
        chk("spurious_sent", longint'(sent_cnt), 2**AW);
        chk("spurious_idle", longint'({busy, done, err}), 0);
        chk("spurious_no_we", wq.size() - bw, 0);

        // start pulsed while busy is ignored
        bw = wq.size(); br = rq.size(); bd = done_cnt;
        tx_dly = 20;
        start_pulse(3);
        repeat (12) tick();
        start_pulse(7);
        wait_end("busy_start", 400);
        chk("busy_start_sent", longint'(sent_cnt), 3);
        chk("busy_start_writes", wq.size() - bw, 5);
        chk("busy_start_done", done_cnt - bd, 1);
        chk_seq("busy_start", bw, br, 5, 3);

        // asynchronous reset while csr_we is high
        tx_dly = 5;
        start_pulse(3);
        chk("rst_pre_we", longint'({csr_we, busy}), 2'b11);
        rst = 1'b1;
        #1;
        chk("rst_async", longint'({csr_we, busy, csr_a}), 0);
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        bw = wq.size();
        repeat (5) tick();
        chk("rst_release_quiet", longint'({busy, csr_we, mem_rd}) + (wq.size() - bw), 0);
        bw = wq.size(); br = rq.size();
        start_pulse(2);
        wait_end("post_rst", 200);
        chk("post_rst_sent", longint'(sent_cnt), 2);
        chk_seq("post_rst", bw, br, 4, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_prog_sender.md
Name: uart_prog_sender

Overview:
Hardware sequencer that downloads a program image into the fwrisc UART program loader. It drives the op_uart CSR write port (csr_a/csr_we/csr_di) in place of a host or bench. It configures the UART once, then streams an image byte-by-byte from a synchronous byte memory, pacing each write on the UART tx_irq. It reports done, error (tx timeout / abort) and progress to the system.

Parameters:
AW, 12, image memory address width (image depth 2**AW bytes).
DIVISOR, 16'd27, value written to the op_uart divisor register (50 MHz, 115200 baud).
TX_TIMEOUT, 20000, max sys_clk cycles to wait for a tx_irq rising edge after each byte write.

Ports:
sys_clk  in  1  system clock (same domain as op_uart).
sys_rst  in  1  asynchronous reset, active-high.
start  in  1  single-cycle request; sampled only in IDLE, DONE or ERR.
abort  in  1  level; forces ERR from any non-IDLE state.
img_len  in  AW+1  byte count, 0..2**AW; sampled on accepted start.
mem_rd  out  1  image memory read strobe.
mem_addr  out  AW  image memory byte address.
mem_data  in  8  read data, valid the cycle after mem_rd.
csr_a  out  14  op_uart CSR address.
csr_we  out  1  op_uart CSR write strobe.
csr_di  out  32  op_uart CSR write data.
tx_irq  in  1  op_uart transmit-complete interrupt.
busy  out  1  high from accepted start until DONE/ERR.
done  out  1  one-cycle pulse when the last byte's tx_irq is seen.
err  out  1  sticky; cleared on next accepted start.
sent_cnt  out  AW+1  bytes confirmed by tx_irq.

Behaviour:
- All outputs are registered. Reset values: csr_we=0, csr_a=0, csr_di=0, mem_rd=0, mem_addr=0, busy=0, done=0, err=0, sent_cnt=0, FSM=IDLE, tx_irq edge register=0.
- CSR map (word address in csr_a[1:0], upper bits 0):
  - 0 = RXTX data, csr_a=14'h0000.
  - 1 = divisor, csr_a=14'h0001.
  - 2 = thru, csr_a=14'h0002.
- FSM: IDLE -> CFG_DIV -> CFG_THRU -> FETCH -> LOAD -> WRITE -> WAIT_TX -> (FETCH | DONE); ERR; DONE returns to IDLE after 1 cycle.
- Accepted start at cycle T with img_len>0:
  - T+1: CFG_DIV. csr_we=1, csr_a=1, csr_di={16'h0,DIVISOR}. busy=1, err=0, sent_cnt=0, index=0.
  - T+2: CFG_THRU. csr_we=1, csr_a=2, csr_di=0.
  - T+3: FETCH. csr_we=0, mem_rd=1, mem_addr=index.
  - T+4: LOAD. mem_rd=0. mem_data is captured into csr_di[7:0], upper bits 0.
  - T+5: WRITE. csr_we=1 for exactly one cycle, csr_a=0.
  - WAIT_TX: the timeout counter clears on entry and increments each cycle.
- WAIT_TX exit on a tx_irq rising edge (tx_irq & ~tx_irq_q):
  - sent_cnt increments.
  - If index==img_len-1: go to DONE, done=1 for one cycle, busy=0.
  - Otherwise: index increments and the FSM re-enters FETCH on the next cycle.
- tx_irq edges outside WAIT_TX are ignored and never counted.
- Timeout: counter reaching TX_TIMEOUT-1 in WAIT_TX -> ERR. In ERR: err=1, busy=0, csr_we=0, sent_cnt holds.
- abort while busy: ERR on the next cycle. A csr_we in flight completes its single cycle. No further CSR writes or mem reads are issued.
- A tx_irq edge and a timeout in the same cycle: the edge wins.
- abort and a tx_irq edge in the same cycle: abort wins, and sent_cnt still increments.
- Start with img_len==0: go straight to DONE (done pulse at T+1), with no CSR writes and no mem reads.
- start while busy is ignored. Start in ERR or DONE is accepted the same as in IDLE.
- index wrap: img_len=2**AW ends at index 2**AW-1. mem_addr never wraps to 0 within a run.
- sys_rst mid-operation: every output returns to its reset value immediately (asynchronous). csr_we must drop the same instant.

Test Plan:
- img_len=3, mem={8'h01,8'h02,8'h23}, bench tx_irq pulses 50 cycles after each write -> CSR writes (1,27), (2,0), (0,01), (0,02), (0,23); sent_cnt=3; one done pulse; err=0; exactly 3 mem reads at addr 0,1,2.
- img_len=2, tx_irq never asserted -> ERR exactly TX_TIMEOUT cycles after the first data write; err=1, sent_cnt=0, no second data write.
- img_len=4, abort asserted during second WAIT_TX -> err=1, sent_cnt=1, no further csr_we; a new start clears err and reruns from the divisor write.
- img_len=0 -> done pulse at T+1, csr_we never asserted; img_len=4096 (AW=12) -> last mem_addr=4095, sent_cnt=4096.
- Spurious tx_irq edge in IDLE, and start pulsed while busy -> neither changes sent_cnt or the sequence.
- sys_rst asserted while csr_we=1 -> csr_we=0 and busy=0 with no clock edge; FSM is IDLE after release.
